// File: rtl/fir_complex_dec.sv
// Complex-coefficient decimating FIR: TAPS-deep I/Q delay line, one sequential complex MAC per tap.
// Latency: final input pop at cycle t -> output write at t+TAPS+1; one output per DECIMATION pops.
// Backpressure: pops only in S_LOAD with both input FIFOs non-empty; holds S_OUT until both output FIFOs have room.
//
// Ports: clock/reset (sync, active-low); i_in/i_empty/i_rd_en and q_in/q_empty/q_rd_en joint input pop;
// out_real/real_full/real_wr_en and out_imag/imag_full/imag_wr_en joint output push;
// coef_wr_en/coef_addr/coef_real/coef_imag tap write port (accepted only while idle); busy.
module fir_complex_dec #(
    parameter int DATA_SIZE  = 32,
    parameter int TAPS       = 20,
    parameter int DECIMATION = 1,
    parameter int BITS       = 10
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [DATA_SIZE-1:0]    i_in,
    input  logic                    i_empty,
    output logic                    i_rd_en,
    input  logic [DATA_SIZE-1:0]    q_in,
    input  logic                    q_empty,
    output logic                    q_rd_en,
    output logic [DATA_SIZE-1:0]    out_real,
    input  logic                    real_full,
    output logic                    real_wr_en,
    output logic [DATA_SIZE-1:0]    out_imag,
    input  logic                    imag_full,
    output logic                    imag_wr_en,
    input  logic                    coef_wr_en,
    input  logic [$clog2(TAPS)-1:0] coef_addr,
    input  logic [DATA_SIZE-1:0]    coef_real,
    input  logic [DATA_SIZE-1:0]    coef_imag,
    output logic                    busy
);
    localparam int DW = DATA_SIZE;
    localparam int KW = $clog2(TAPS);
    localparam int CW = (DECIMATION > 1) ? $clog2(DECIMATION) : 1;
    localparam int AW = 2 * DW + KW + 1;

    localparam logic [1:0] S_LOAD = 2'd0;
    localparam logic [1:0] S_MAC  = 2'd1;
    localparam logic [1:0] S_OUT  = 2'd2;

    // Coefficient 1.0 in the fixed-point format.
    localparam logic signed [DW-1:0] ONE = DW'(64'd1 << BITS);
    // Bias added to negative sums so the arithmetic shift rounds toward zero.
    localparam logic signed [AW-1:0] RND = AW'((64'd1 << BITS) - 64'd1);

    logic [1:0]             state;
    logic [CW-1:0]          cnt;
    logic [KW-1:0]          k;
    logic signed [DW-1:0]   d_r [TAPS];
    logic signed [DW-1:0]   d_i [TAPS];
    logic signed [DW-1:0]   h_r [TAPS];
    logic signed [DW-1:0]   h_i [TAPS];
    logic signed [AW-1:0]   acc_r, acc_i;
    logic signed [AW-1:0]   acc_r_nxt, acc_i_nxt;
    logic signed [AW-1:0]   adj_r, adj_i;
    logic signed [2*DW-1:0] hr_x, hi_x, xr_x, xi_x;
    logic signed [2*DW-1:0] p_rr, p_ii, p_ri, p_ir;
    logic                   pop, push, coef_we;

    // Handshakes are gated by reset so no FIFO word is lost or written while reset is held.
    assign pop  = reset && (state == S_LOAD) && !i_empty && !q_empty;
    assign push = reset && (state == S_OUT) && !real_full && !imag_full;

    assign i_rd_en    = pop;
    assign q_rd_en    = pop;
    assign real_wr_en = push;
    assign imag_wr_en = push;

    assign busy    = !((state == S_LOAD) && (cnt == '0));
    assign coef_we = coef_wr_en && !busy && (int'(coef_addr) < TAPS);

    // Operands widened first so the products are full 2*DW signed.
    assign hr_x = (2*DW)'(h_r[k]);
    assign hi_x = (2*DW)'(h_i[k]);
    assign xr_x = (2*DW)'(d_r[k]);
    assign xi_x = (2*DW)'(d_i[k]);
    assign p_rr = hr_x * xr_x;
    assign p_ii = hi_x * xi_x;
    assign p_ri = hr_x * xi_x;
    assign p_ir = hi_x * xr_x;

    assign acc_r_nxt = acc_r + AW'(p_rr) - AW'(p_ii);
    assign acc_i_nxt = acc_i + AW'(p_ri) + AW'(p_ir);

    assign adj_r = acc_r_nxt + (acc_r_nxt[AW-1] ? RND : '0);
    assign adj_i = acc_i_nxt + (acc_i_nxt[AW-1] ? RND : '0);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state    <= S_LOAD;
            cnt      <= '0;
            k        <= '0;
            acc_r    <= '0;
            acc_i    <= '0;
            out_real <= '0;
            out_imag <= '0;
            for (int j = 0; j < TAPS; j++) begin
                d_r[j] <= '0;
                d_i[j] <= '0;
                h_r[j] <= '0;
                h_i[j] <= '0;
            end
            h_r[0] <= ONE;
        end else begin
            if (pop) begin
                for (int j = 1; j < TAPS; j++) begin
                    d_r[j] <= d_r[j-1];
                    d_i[j] <= d_i[j-1];
                end
                d_r[0] <= i_in;
                d_i[0] <= q_in;
            end

            if (coef_we) begin
                h_r[coef_addr] <= coef_real;
                h_i[coef_addr] <= coef_imag;
            end

            case (state)
                S_LOAD: begin
                    if (pop) begin
                        if (cnt == CW'(DECIMATION - 1)) begin
                            cnt   <= '0;
                            k     <= '0;
                            acc_r <= '0;
                            acc_i <= '0;
                            state <= S_MAC;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                S_MAC: begin
                    acc_r <= acc_r_nxt;
                    acc_i <= acc_i_nxt;
                    if (k == KW'(TAPS - 1)) begin
                        // Final sum includes this cycle's product, so use the next-state value.
                        out_real <= DW'(adj_r >>> BITS);
                        out_imag <= DW'(adj_i >>> BITS);
                        state    <= S_OUT;
                    end else begin
                        k <= k + KW'(1);
                    end
                end
                S_OUT: begin
                    if (push) begin
                        state <= S_LOAD;
                    end
                end
                default: state <= S_LOAD;
            endcase
        end
    end
endmodule

// File: tb/tb_fir_complex_dec.sv
module tb_fir_complex_dec;
    localparam int DW   = 32;
    localparam int TAPS = 20;
    localparam int BITS = 10;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset;

    // Main instance, DECIMATION = 1
    logic [DW-1:0] i_in, q_in, out_real, out_imag, coef_real, coef_imag;
    logic          i_empty, q_empty, i_rd_en, q_rd_en;
    logic          real_full, imag_full, real_wr_en, imag_wr_en;
    logic          coef_wr_en, busy;
    logic [4:0]    coef_addr;

    // Second instance, DECIMATION = 4
    logic [DW-1:0] d4_i_in, d4_q_in, d4_out_real, d4_out_imag;
    logic          d4_i_empty, d4_q_empty, d4_i_rd_en, d4_q_rd_en;
    logic          d4_real_full, d4_imag_full, d4_real_wr_en, d4_imag_wr_en;
    logic          d4_coef_wr_en, d4_busy;

    fir_complex_dec #(.DATA_SIZE(DW), .TAPS(TAPS), .DECIMATION(1), .BITS(BITS)) u_dut (
        .clock(clock), .reset(reset),
        .i_in(i_in), .i_empty(i_empty), .i_rd_en(i_rd_en),
        .q_in(q_in), .q_empty(q_empty), .q_rd_en(q_rd_en),
        .out_real(out_real), .real_full(real_full), .real_wr_en(real_wr_en),
        .out_imag(out_imag), .imag_full(imag_full), .imag_wr_en(imag_wr_en),
        .coef_wr_en(coef_wr_en), .coef_addr(coef_addr),
        .coef_real(coef_real), .coef_imag(coef_imag), .busy(busy)
    );

    fir_complex_dec #(.DATA_SIZE(DW), .TAPS(TAPS), .DECIMATION(4), .BITS(BITS)) u_d4 (
        .clock(clock), .reset(reset),
        .i_in(d4_i_in), .i_empty(d4_i_empty), .i_rd_en(d4_i_rd_en),
        .q_in(d4_q_in), .q_empty(d4_q_empty), .q_rd_en(d4_q_rd_en),
        .out_real(d4_out_real), .real_full(d4_real_full), .real_wr_en(d4_real_wr_en),
        .out_imag(d4_out_imag), .imag_full(d4_imag_full), .imag_wr_en(d4_imag_wr_en),
        .coef_wr_en(d4_coef_wr_en), .coef_addr(coef_addr),
        .coef_real(coef_real), .coef_imag(coef_imag), .busy(d4_busy)
    );

    int src_i[$], src_q[$], d4_src_i[$], d4_src_q[$];
    int exp_r[$], exp_i[$], d4_exp_r[$], d4_exp_i[$];

    int checks = 0, errors = 0, cyc = 0;
    int rd_cnt = 0, d4_rd_cnt = 0, wr_cnt = 0;
    int last_pop = 0, d4_last_pop = 0;
    bit lat_chk = 1'b0;

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Input FIFO model: first-word-fall-through view of the source queues.
    task automatic drive_fifos();
        i_empty    = (src_i.size() == 0);
        q_empty    = i_empty;
        i_in       = i_empty ? '0 : src_i[0];
        q_in       = i_empty ? '0 : src_q[0];
        d4_i_empty = (d4_src_i.size() == 0);
        d4_q_empty = d4_i_empty;
        d4_i_in    = d4_i_empty ? '0 : d4_src_i[0];
        d4_q_in    = d4_i_empty ? '0 : d4_src_q[0];
    endtask

    // One clock: observe on the falling edge, update FIFO fronts just after the rising edge.
    task automatic tick();
        int er, ei;
        @(negedge clock);
        cyc++;
        if (i_rd_en || q_rd_en) begin
            check("rd_pair", i_rd_en & q_rd_en, 1);
            rd_cnt++;
            last_pop = cyc;
            if (src_i.size() > 0) begin
                void'(src_i.pop_front());
                void'(src_q.pop_front());
            end else check("pop_when_empty", 1, 0);
        end
        if (real_wr_en || imag_wr_en) begin
            wr_cnt++;
            check("wr_pair", real_wr_en & imag_wr_en, 1);
            check("wr_not_full", real_full | imag_full, 0);
            if (exp_r.size() == 0) check("unexpected_wr", 1, 0);
            else begin
                er = exp_r.pop_front();
                ei = exp_i.pop_front();
                check("out_real", $signed(out_real), er);
                check("out_imag", $signed(out_imag), ei);
                if (lat_chk) check("latency", cyc - last_pop, TAPS + 1);
            end
        end
        if (d4_i_rd_en || d4_q_rd_en) begin
            check("d4_rd_pair", d4_i_rd_en & d4_q_rd_en, 1);
            d4_rd_cnt++;
            d4_last_pop = cyc;
            if (d4_src_i.size() > 0) begin
                void'(d4_src_i.pop_front());
                void'(d4_src_q.pop_front());
            end else check("d4_pop_when_empty", 1, 0);
        end
        if (d4_real_wr_en || d4_imag_wr_en) begin
            check("d4_wr_pair", d4_real_wr_en & d4_imag_wr_en, 1);
            if (d4_exp_r.size() == 0) check("d4_unexpected_wr", 1, 0);
            else begin
                er = d4_exp_r.pop_front();
                ei = d4_exp_i.pop_front();
                check("d4_out_real", $signed(d4_out_real), er);
                check("d4_out_imag", $signed(d4_out_imag), ei);
                if (lat_chk) check("d4_latency", cyc - d4_last_pop, TAPS + 1);
            end
        end
        @(posedge clock);
        #1;
        drive_fifos();
    endtask

    task automatic push(input int i, input int q, input int er, input int ei);
        src_i.push_back(i);
        src_q.push_back(q);
        exp_r.push_back(er);
        exp_i.push_back(ei);
        drive_fifos();
    endtask

    task automatic push_src(input int i, input int q);
        src_i.push_back(i);
        src_q.push_back(q);
        drive_fifos();
    endtask

    task automatic write_coef(input int addr, input int r, input int i);
        coef_addr  = 5'(addr);
        coef_real  = r;
        coef_imag  = i;
        coef_wr_en = 1'b1;
        tick();
        coef_wr_en = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while ((exp_r.size() > 0 || d4_exp_r.size() > 0) && n < budget) begin
            tick();
            n++;
        end
        check(tag, exp_r.size() + d4_exp_r.size(), 0);
        exp_r.delete(); exp_i.delete(); d4_exp_r.delete(); d4_exp_i.delete();
    endtask

    initial begin
        int r0, w0;
        reset = 1'b0;
        real_full = 1'b0; imag_full = 1'b0;
        d4_real_full = 1'b0; d4_imag_full = 1'b0;
        coef_wr_en = 1'b0; d4_coef_wr_en = 1'b0;
        coef_addr = '0; coef_real = '0; coef_imag = '0;
        drive_fifos();

        // Reset state
        tick();
        tick();
        check("rst_out_real", out_real, 0);
        check("rst_out_imag", out_imag, 0);
        check("rst_wr_en", real_wr_en | imag_wr_en, 0);
        check("rst_rd_en", i_rd_en | q_rd_en, 0);
        check("rst_busy", busy, 0);
        reset = 1'b1;

        // Identity taps pass samples through, 21-cycle pop-to-write latency
        lat_chk = 1'b1;
        push(100, -50, 100, -50);
        push(7, 8, 7, 8);
        drain("t1_drain", 200);

        // Two real unit taps: running pairwise sum
        do_reset();
        write_coef(1, 1024, 0);
        push(1, 0, 1, 0);
        push(2, 0, 3, 0);
        push(3, 0, 5, 0);
        drain("t2_drain", 200);

        // Decimation by 4: eight pops, two outputs
        do_reset();
        r0 = d4_rd_cnt;
        for (int s = 1; s <= 8; s++) begin
            d4_src_i.push_back(s);
            d4_src_q.push_back(-s);
        end
        d4_exp_r.push_back(4); d4_exp_i.push_back(-4);
        d4_exp_r.push_back(8); d4_exp_i.push_back(-8);
        drive_fifos();
        drain("t4_drain", 200);
        check("t4_rd_count", d4_rd_cnt - r0, 8);

        // Complex tap j*1.0, then (1+j) written in the same cycle as the pop
        do_reset();
        write_coef(0, 0, 1024);
        push(3, 4, -4, 3);
        drain("t3a_drain", 200);
        coef_addr = 5'd0; coef_real = 1024; coef_imag = 1024; coef_wr_en = 1'b1;
        push(1, 1, 0, 2);
        tick();
        coef_wr_en = 1'b0;
        drain("t3b_drain", 200);

        // Half-gain tap: truncation toward zero for both signs
        do_reset();
        write_coef(0, 512, 0);
        push(-3, 0, -1, 0);
        push(3, 0, 1, 0);
        drain("t5a_drain", 200);

        // Output backpressure: stall in S_OUT with an input sample waiting
        lat_chk = 1'b0;
        real_full = 1'b1;
        push(10, 20, 5, 10);
        push(-7, 0, -3, 0);
        repeat (25) tick();
        check("t5_busy_stall", busy, 1);
        r0 = rd_cnt;
        repeat (20) tick();
        check("t5_no_rd", rd_cnt - r0, 0);
        check("t5_no_wr", exp_r.size(), 2);
        check("t5_hold_real", $signed(out_real), 5);
        real_full = 1'b0;
        imag_full = 1'b1;
        repeat (5) tick();
        check("t5_imag_full_no_wr", exp_r.size(), 2);
        imag_full = 1'b0;
        drain("t5b_drain", 200);
        lat_chk = 1'b1;

        // Coefficient write while busy is ignored
        do_reset();
        push(9, -2, 9, -2);
        repeat (5) tick();
        check("t6_busy_mac", busy, 1);
        write_coef(0, 0, 0);
        drain("t6a_drain", 200);
        push(6, 6, 6, 6);
        drain("t6b_drain", 200);

        // Reset mid-MAC aborts the output and restores identity taps
        write_coef(0, 2048, 0);
        push_src(11, 12);
        repeat (8) tick();
        w0 = wr_cnt;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        repeat (40) tick();
        check("t6_abort_no_wr", wr_cnt - w0, 0);
        push(5, -5, 5, -5);
        drain("t6c_drain", 200);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
